// File: rtl/sram_controller.sv
// Sequences 32-bit MEM-stage loads/stores as two 16-bit external SRAM cycles
// and stalls the pipeline through `ready` until the fixed access latency has elapsed.
module sram_controller #(
  parameter int          ACCESS_CYCLES = 6,
  parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic [1:0]  dbg_state,
  output logic [3:0]  dbg_cnt,
  output logic        dbg_dq_oe
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        op_wr_q, op_wr_d;
  logic [16:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] read_data_q, read_data_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic        we_n_q, we_n_d;
  logic        dq_oe_q, dq_oe_d;
  logic [15:0] dq_out_q, dq_out_d;

  logic        req;
  logic [18:0] offset;
  logic        unused_bits;

  // Only bits [18:2] of the rebased address reach the SRAM; the low-bit
  // subtraction equals the low bits of the full modulo-2^32 subtraction.
  assign req         = wr_en | rd_en;
  assign offset      = address[18:0] - BASE_ADDR[18:0];
  assign unused_bits = ^{address[31:19], offset[1:0]};

  // Handshake: a request is a level held on wr_en/rd_en; ready=0 while it is
  // being served and ready=1 for the single DONE cycle, on whose closing edge
  // the pipeline advances. With no request ready stays 1.
  assign ready = ~req | (state_q == DONE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_wr_d     = op_wr_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    sram_addr_d = sram_addr_q;
    we_n_d      = 1'b1;
    dq_oe_d     = 1'b0;
    dq_out_d    = dq_out_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          // Bus outputs are registered, so the low half is set up on entry.
          op_wr_d     = wr_en;
          wdata_d     = write_data;
          word_d      = offset[18:2];
          cnt_d       = 4'd1;
          state_d     = ACCESS;
          sram_addr_d = {offset[18:2], 1'b0};
          we_n_d      = ~wr_en;
          dq_oe_d     = wr_en;
          dq_out_d    = write_data[15:0];
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd1) begin
          sram_addr_d = {word_q, 1'b1};
          we_n_d      = ~op_wr_q;
          dq_oe_d     = op_wr_q;
          dq_out_d    = wdata_q[31:16];
          if (!op_wr_q) read_data_d[15:0] = SRAM_DQ;
        end
        if (cnt_q == 4'd2 && !op_wr_q) read_data_d[31:16] = SRAM_DQ;
        if (cnt_q == 4'(ACCESS_CYCLES - 1)) begin
          state_d = DONE;
          cnt_d   = 4'd0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      op_wr_q     <= 1'b0;
      word_q      <= 17'd0;
      wdata_q     <= 32'd0;
      read_data_q <= 32'd0;
      sram_addr_q <= 18'd0;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_wr_q     <= op_wr_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      we_n_q      <= we_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
    end
  end

  assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
  assign read_data = read_data_q;
  assign dbg_state = state_q;
  assign dbg_cnt   = cnt_q;
  assign dbg_dq_oe = dq_oe_q;

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Sequences the single-port 16-bit external SRAM on behalf of the MEM stage.
- Drives the `ready` signal consumed by every pipeline register (IF_ID, ID_EXE, EXE_MEM, MEM_WB). While an access is in flight, `ready`=0 and the whole pipeline holds.
- Splits each 32-bit load/store into two 16-bit SRAM half-word cycles.
- Applies a fixed, parameterised access latency that models SRAM timing.

Parameters:
- ACCESS_CYCLES, 6, total cycles `ready` stays low per access (legal range 3..15).
- BASE_ADDR, 32'd1024, CPU data-address base subtracted before mapping to SRAM.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  store request from EXE_MEM, level, held until ready.
- rd_en  in  1  load request from EXE_MEM, level, held until ready.
- address  in  32  CPU byte address (ALU result).
- write_data  in  32  store data.
- read_data  out  32  load data, registered.
- ready  out  1  0 = access in progress, freeze pipeline.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  18  SRAM half-word address.
- SRAM_WE_N  out  1  SRAM write enable, active low.
- SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  out  1 each  tied 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0.
  - read_data=0, SRAM_ADDR=0, SRAM_WE_N=1, SRAM_DQ=Z.
  - Latched op, address and data cleared.
- Request: req = wr_en | rd_en. If both are set, the access is a write.
- ready (combinational): ready = ~req | (state==DONE).
  - With no request, ready=1.
  - After reset with a request still held, ready=0.
- States:
  - IDLE:
    - On req: latch op, wdata and word = (address-BASE_ADDR)[18:2] (17 bits); cnt<=1; go to ACCESS.
    - SRAM is idle in this cycle.
  - ACCESS:
    - cnt==1: SRAM_ADDR={word,1'b0}, low half.
    - cnt==2: SRAM_ADDR={word,1'b1}, high half.
    - cnt>2: SRAM_ADDR holds {word,1'b1}, SRAM_WE_N=1, DQ=Z (wait states).
    - cnt increments each cycle. At cnt==ACCESS_CYCLES-1, go to DONE.
  - DONE: ready=1 for exactly one cycle, read_data valid; next state IDLE.
- Timing:
  - A request first seen in cycle 0 gives ready=0 for cycles 0..ACCESS_CYCLES-1 and ready=1 in cycle ACCESS_CYCLES.
  - The pipeline advances on the edge that ends DONE.
- Write:
  - SRAM_WE_N=0 only during cnt==1 and cnt==2.
  - SRAM_DQ = wdata[15:0] during cnt==1 and wdata[31:16] during cnt==2; Z otherwise.
  - read_data is unchanged by a write.
- Read:
  - SRAM_WE_N=1 and DQ=Z throughout.
  - read_data[15:0] <= SRAM_DQ at the end of cnt==1; read_data[31:16] <= SRAM_DQ at the end of cnt==2.
  - read_data then holds until the next read completes.
- Back-to-back: if req is still high in the IDLE cycle after DONE, a new access starts. The same level is the next instruction's request; the controller has no re-trigger suppression.
- Request deasserted mid-access: the access still completes on its latched values. ready reads 1 because req=0.
- Address arithmetic: subtraction is modulo 2^32. Bits above [18] are discarded with no range check.
- Reset during ACCESS: the access is aborted immediately, a partial write may remain in SRAM, and the state returns to IDLE.

Test Plan:
- Idle and reset:
  - Apply rst=0 then release with no request: ready=1, SRAM_WE_N=1, read_data=0, DQ=Z.
  - Hold rst=0 and assert rd_en: ready=0.
- Store, then load back:
  - wr_en=1, address=1024, write_data=0xDEADBEEF: SRAM_ADDR=0 with DQ=0xBEEF (WE_N=0), then SRAM_ADDR=1 with DQ=0xDEAD; ready=0 for 6 cycles, then 1.
  - Follow with rd_en=1 at address=1024: read_data=0xDEADBEEF in the DONE cycle.
- Address mapping:
  - wr_en at address=1032: SRAM_ADDR=4 then 5.
  - rd_en at address=1028 after storing 0x12345678 there: read_data=0x12345678.
- Latency parameter:
  - ACCESS_CYCLES=3, rd_en held for two consecutive accesses: ready pattern 0,0,0,1,0,0,0,1.
- Priority: rd_en=1 and wr_en=1 together, write_data=0x0000FFFF, address=1024: a write occurs (WE_N=0 for 2 cycles) and read_data is unchanged.
- Abort: assert rst=0 while cnt==2 of a write: SRAM_WE_N=1 and DQ=Z immediately; after release the next rd_en completes in 6 cycles.
